// File: rtl/router_fifo_pkg.sv
// Shared constants and helpers for the router packet FIFO.
package router_fifo_pkg;

  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefDepth  = 16;
  localparam int unsigned DefLenLsb = 2;

  // Header tag sits just above the data byte in each stored word
  localparam int unsigned HDR_TAG_BIT = DefDataW;

  // Ceiling log2 usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage array for the router packet FIFO.
// Synchronous write, registered read data with enable and clear, plus a
// combinational peek of the word at the read address.
module router_fifo_mem
  import router_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefDataW + 1,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    re,
  input  logic                    clr,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rd_word,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Array write; contents are deliberately never cleared
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port, held when not reading
  always_ff @(posedge clock) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

  assign rd_word = mem_q[raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO: header tagging, remaining-byte tracking,
// occupancy flags and a packet-done pulse on the last (parity) byte read.
// Optional sticky overflow/underflow flags: define ROUTER_PKT_FIFO_ERR_EN.
module router_pkt_fifo
  import router_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned LEN_LSB  = DefLenLsb,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    read_enb,
  input  logic                    lfd_state,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [clog2(DEPTH):0]   level,
  output logic                    pkt_busy,
  output logic                    pkt_done,
  output logic                    ovf_err,
  output logic                    udf_err
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = DATA_W - LEN_LSB;
  localparam int unsigned RW = LW + 1;
  localparam logic [AW:0] PtrOne   = (AW+1)'(1);
  localparam logic [AW:0] AfullLvl = (AW+1)'(AFULL_TH);

  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic            lfd_q;
  logic [RW-1:0]   rem_q, rem_d;
  logic            done_q, done_d;
  logic            clr, wr_acc, rd_acc;
  logic [DATA_W:0] rd_word, rdata;
  logic [LW-1:0]   hdr_len;

  assign clr    = reset | soft_reset;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level  = wr_ptr_q - rd_ptr_q;
  assign almost_full = (level >= AfullLvl);
  // Flags of the current cycle decide: full drops the write, empty drops the read
  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .we      (wr_acc),
    .waddr   (wr_ptr_q[AW-1:0]),
    .wdata   ({lfd_q, data_in}),
    .re      (rd_acc),
    .clr     (clr),
    .raddr   (rd_ptr_q[AW-1:0]),
    .rd_word (rd_word),
    .rdata   (rdata)
  );

  assign data_out = rdata[DATA_W-1:0];
  assign hdr_len  = rd_word[DATA_W-1:LEN_LSB];

  // Pointers advance on accepted transfers; header tag tracks lfd_state one cycle late
  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lfd_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
      lfd_q <= lfd_state;
    end
  end

  // Header read loads payload+parity count; other reads count it down
  always_comb begin
    rem_d  = rem_q;
    done_d = 1'b0;
    if (rd_acc) begin
      if (rd_word[DATA_W]) begin
        rem_d = {1'b0, hdr_len} + RW'(1);
      end else if (rem_q != '0) begin
        rem_d  = rem_q - RW'(1);
        done_d = (rem_q == RW'(1));
      end
    end
  end

  // Packet counter and done-pulse registers
  always_ff @(posedge clock) begin
    if (clr) begin
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  assign pkt_busy = (rem_q != '0);
  assign pkt_done = done_q;

`ifdef ROUTER_PKT_FIFO_ERR_EN
  logic ovf_q, udf_q;

  // Sticky misuse flags, cleared only by either reset
  always_ff @(posedge clock) begin
    if (clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (write_enb && full) ovf_q <= 1'b1;
      if (read_enb && empty) udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed packet/boundary sequences
// followed by random traffic, all compared against a queue-based model.
module tb_router_pkt_fifo;

  localparam int Depth = 16;
  localparam int Afull = Depth - 2;
`ifdef ROUTER_PKT_FIFO_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, pkt_busy, pkt_done, ovf_err, udf_err;
  logic [4:0] level;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [8:0] mq[$];
  logic       m_lfd, m_done, m_ovf, m_udf;
  logic [7:0] m_dout;
  int         m_rem;

  router_pkt_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .pkt_busy    (pkt_busy),
    .pkt_done    (pkt_done),
    .ovf_err     (ovf_err),
    .udf_err     (udf_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    int sz;
    bit aw, ar;
    logic [8:0] e;
    sz = mq.size();
    aw = write_enb && (sz < Depth);
    ar = read_enb && (sz > 0);
    if (reset || soft_reset) begin
      mq.delete();
      m_lfd = 1'b0; m_rem = 0; m_dout = 8'h00; m_done = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ErrEn && write_enb && sz == Depth) m_ovf = 1'b1;
      if (ErrEn && read_enb && sz == 0) m_udf = 1'b1;
      if (ar) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) begin
          m_rem = int'(e[7:2]) + 1;
        end else if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_done = 1'b1;
        end
      end
      if (aw) mq.push_back({m_lfd, data_in});
      m_lfd = lfd_state;
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    check_eq("data_out",    32'(data_out),    32'(m_dout));
    check_eq("full",        32'(full),        32'(sz == Depth));
    check_eq("empty",       32'(empty),       32'(sz == 0));
    check_eq("almost_full", 32'(almost_full), 32'(sz >= Afull));
    check_eq("level",       32'(level),       32'(sz));
    check_eq("pkt_busy",    32'(pkt_busy),    32'(m_rem != 0));
    check_eq("pkt_done",    32'(pkt_done),    32'(m_done));
    check_eq("ovf_err",     32'(ovf_err),     32'(m_ovf));
    check_eq("udf_err",     32'(udf_err),     32'(m_udf));
  endtask

  task automatic cyc(input logic w, input logic r, input logic l, input logic [7:0] d,
                     input logic s, input logic rs);
    write_enb = w; read_enb = r; lfd_state = l; data_in = d; soft_reset = s; reset = rs;
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [7:0] d); cyc(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic rd();                    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0); endtask

  initial begin
    m_lfd = 0; m_rem = 0; m_dout = 0; m_done = 0; m_ovf = 0; m_udf = 0;

    // Reset for two cycles
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_dout",  32'(data_out), 32'd0);

    // Single packet: header 0x0D (length 3), 3 payload, parity
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    wr(8'h0D); wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'h5C);
    check_eq("pkt_level", 32'(level), 32'd5);
    rd();
    check_eq("pkt_busy_hdr", 32'(pkt_busy), 32'd1);
    for (int i = 0; i < 4; i++) rd();
    check_eq("pkt_done_parity", 32'(pkt_done), 32'd1);
    rd(); // read while empty

    // Fill to full, one dropped write, drain in order
    for (int i = 0; i < Depth; i++) wr(8'(8'h30 + i));
    check_eq("fill_full",  32'(full),  32'd1);
    check_eq("fill_level", 32'(level), 32'd16);
    wr(8'hEE);
    check_eq("ovf_flag", 32'(ovf_err), 32'(ErrEn));
    for (int i = 0; i < Depth; i++) rd();

    // Pointer wrap, then concurrent traffic at level 8
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12; i++) wr(8'($urandom));
      for (int i = 0; i < 12; i++) rd();
    end
    for (int i = 0; i < 8; i++) wr(8'(8'h80 + i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h90 + i), 1'b0, 1'b0);
    check_eq("rw_level8", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) rd();

    // Full + rd&wr, then empty + rd&wr
    for (int i = 0; i < Depth; i++) wr(8'(8'h40 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    check_eq("full_rw_level", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) rd();
    cyc(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    check_eq("empty_rw_level", 32'(level), 32'd1);
    check_eq("empty_rw_dout",  32'(data_out), 32'h4F);
    rd();

    // soft_reset in the middle of a packet
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    wr(8'h0D); wr(8'hB1); wr(8'hB2); wr(8'hB3); wr(8'hB4); wr(8'hB5);
    rd(); rd();
    check_eq("srst_pre_level", 32'(level), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("srst_empty", 32'(empty), 32'd1);
    check_eq("srst_busy",  32'(pkt_busy), 32'd0);

    // Random traffic with occasional headers and flushes
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 7) == 0), 8'($urandom),
          1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 999) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
